// File: rtl/dma_start_arbiter_mc.sv
`default_nettype none
// ============================================================================
// Module   : dma_start_arbiter_mc
// Purpose  : Multi-source start controller for the DMA transfer engine.
//            Keeps one pending flag per internal buffer descriptor (BD).
//            Offers one pending BD at a time to the engine over a valid/ready
//            handshake. Arbitration is round-robin, fixed priority, or
//            two-level priority with anti-starvation aging.
// Ports    : clock, reset      - clock, asynchronous active-high reset
//            start_req         - start pulses, bit [s*NUM_INT_BDS+i] = src s, BD i
//            cancel            - per-BD pending clear (also withdraws an offer)
//            hi_pri            - per-BD high-priority level (ARB_MODE 2)
//            eng_ready         - engine accepts the offered BD
//            gnt_valid, gnt_id - registered BD offer
//            pending           - pending flags
//            drop_sts/drop_clr - sticky "start while already pending", W1C
// Revision : 1.0 - initial release
// ============================================================================
module dma_start_arbiter_mc #(
    parameter int NUM_INT_BDS  = 4,
    parameter int NUM_SRC      = 2,
    parameter int ID_WIDTH     = 2,
    parameter int ARB_MODE     = 0,
    parameter int AGE_WIDTH    = 8,
    parameter int STARVE_LIMIT = 200
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_SRC*NUM_INT_BDS-1:0] start_req,
    input  logic [NUM_INT_BDS-1:0]         cancel,
    input  logic [NUM_INT_BDS-1:0]         hi_pri,
    input  logic                           eng_ready,
    output logic                           gnt_valid,
    output logic [ID_WIDTH-1:0]            gnt_id,
    output logic [NUM_INT_BDS-1:0]         pending,
    output logic [NUM_INT_BDS-1:0]         drop_sts,
    input  logic [NUM_INT_BDS-1:0]         drop_clr
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    localparam logic [AGE_WIDTH-1:0] c_age_max   = {AGE_WIDTH{1'b1}};
    localparam logic [AGE_WIDTH-1:0] c_age_limit = AGE_WIDTH'(STARVE_LIMIT);

    state_t                   r_state;
    logic [ID_WIDTH-1:0]      r_ptr;

    logic [NUM_INT_BDS-1:0]   w_req_any;
    logic [NUM_INT_BDS-1:0]   w_acc;
    logic [NUM_INT_BDS-1:0]   w_is_offer;
    logic [NUM_INT_BDS-1:0]   w_pending_nxt;
    logic [NUM_INT_BDS-1:0]   w_drop_set;
    logic [NUM_INT_BDS-1:0]   w_aged;
    logic [NUM_INT_BDS-1:0]   w_hi;
    logic [NUM_INT_BDS-1:0]   w_elig;
    logic [2*NUM_INT_BDS-1:0] w_rot;
    logic                     w_accept;
    logic                     w_cancel_cur;
    logic                     w_found;
    logic [ID_WIDTH-1:0]      w_winner;
    logic [ID_WIDTH-1:0]      w_ptr_inc;
    int                       w_sum;

    // Only OFFER ever drives gnt_valid high, so this is the acceptance event.
    assign w_accept = gnt_valid & eng_ready;

    // ------------------------------------------------------------------
    // Per-BD request merge, offer/accept decode, pending and drop update
    // ------------------------------------------------------------------
    always_comb begin
        w_req_any    = '0;
        w_is_offer   = '0;
        w_cancel_cur = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int i = 0; i < NUM_INT_BDS; i++) begin
                w_req_any[i] = w_req_any[i] | start_req[s*NUM_INT_BDS + i];
            end
        end
        // Decoded by comparison so that unused codes of gnt_id never index
        // past the BD range.
        for (int i = 0; i < NUM_INT_BDS; i++) begin
            w_is_offer[i] = gnt_valid && (gnt_id == ID_WIDTH'(i));
            w_cancel_cur  = w_cancel_cur | (w_is_offer[i] & cancel[i]);
        end
        w_acc = w_is_offer & {NUM_INT_BDS{eng_ready}};

        // cancel beats a start, a start beats acceptance (re-queue)
        w_pending_nxt = ~cancel & (w_req_any | (pending & ~w_acc));
        w_drop_set    = w_req_any & pending & ~w_acc & ~cancel;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending  <= '0;
            drop_sts <= '0;
        end else begin
            pending  <= w_pending_nxt;
            drop_sts <= w_drop_set | (drop_sts & ~drop_clr);
        end
    end

    // ------------------------------------------------------------------
    // Aging: only meaningful in two-level mode, tied off otherwise
    // ------------------------------------------------------------------
    generate
        if (ARB_MODE == 2) begin : g_age_on
            for (genvar i = 0; i < NUM_INT_BDS; i++) begin : g_bd
                logic [AGE_WIDTH-1:0] r_age;
                logic                 r_aged;
                logic [AGE_WIDTH-1:0] w_age_inc;
                logic                 w_cand;

                assign w_cand    = pending[i] & ~hi_pri[i] & ~w_is_offer[i];
                assign w_age_inc = (r_age == c_age_max) ? r_age : r_age + 1'b1;
                assign w_aged[i] = r_aged;

                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_age  <= '0;
                        r_aged <= 1'b0;
                    end else if (!w_pending_nxt[i]) begin
                        r_age  <= '0;
                        r_aged <= 1'b0;
                    end else if (w_cand) begin
                        r_age <= w_age_inc;
                        if (w_age_inc >= c_age_limit) begin
                            r_aged <= 1'b1;
                        end
                    end
                end
            end
        end else begin : g_age_off
            assign w_aged = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Winner selection
    // ------------------------------------------------------------------
    always_comb begin
        w_hi     = pending & (hi_pri | w_aged);
        w_elig   = pending;
        if ((ARB_MODE == 2) && (|w_hi)) begin
            w_elig = w_hi;
        end
        // Rotating a doubled copy right by the pointer makes bit k of the
        // low half correspond to BD (ptr + k) mod NUM_INT_BDS.
        w_rot    = {w_elig, w_elig} >> r_ptr;
        w_winner = '0;
        w_found  = 1'b0;
        w_sum    = 0;
        if (ARB_MODE == 1) begin
            for (int i = 0; i < NUM_INT_BDS; i++) begin
                if (!w_found && pending[i]) begin
                    w_winner = ID_WIDTH'(i);
                    w_found  = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < NUM_INT_BDS; k++) begin
                if (!w_found && w_rot[k]) begin
                    w_sum = int'(r_ptr) + k;
                    if (w_sum >= NUM_INT_BDS) begin
                        w_sum = w_sum - NUM_INT_BDS;
                    end
                    w_winner = ID_WIDTH'(w_sum);
                    w_found  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_ptr_inc = '0;
        if ((int'(gnt_id) + 1) < NUM_INT_BDS) begin
            w_ptr_inc = gnt_id + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Offer FSM: new winners are only picked in IDLE, so consecutive
    // offers always have at least one idle cycle between them.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
            r_ptr     <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (|pending) begin
                        gnt_id    <= w_winner;
                        gnt_valid <= 1'b1;
                        r_state   <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    if (w_accept) begin
                        // acceptance wins over a coincident cancel
                        gnt_valid <= 1'b0;
                        r_ptr     <= w_ptr_inc;
                        r_state   <= ST_IDLE;
                    end else if (w_cancel_cur) begin
                        // withdraw, pointer untouched
                        gnt_valid <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    gnt_valid <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_start_arbiter_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_start_arbiter_mc
// Purpose  : Self-checking bench for dma_start_arbiter_mc. Three instances
//            (round-robin, fixed priority, two-level with STARVE_LIMIT 10)
//            share one stimulus set; each phase resets and checks one of them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_start_arbiter_mc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] start_req = '0;
    logic [3:0] cancel    = '0;
    logic [3:0] hi_pri    = 4'b0011;
    logic [3:0] drop_clr  = '0;
    logic       eng_ready = 1'b0;

    logic       gv0, gv1, gv2;
    logic [1:0] gid0, gid1, gid2;
    logic [3:0] pend0, pend1, pend2;
    logic [3:0] drop0, drop1, drop2;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    dma_start_arbiter_mc #(.ARB_MODE(0)) u_rr (
        .clock(clock), .reset(reset), .start_req(start_req), .cancel(cancel),
        .hi_pri(hi_pri), .eng_ready(eng_ready), .gnt_valid(gv0), .gnt_id(gid0),
        .pending(pend0), .drop_sts(drop0), .drop_clr(drop_clr)
    );

    dma_start_arbiter_mc #(.ARB_MODE(1)) u_fp (
        .clock(clock), .reset(reset), .start_req(start_req), .cancel(cancel),
        .hi_pri(hi_pri), .eng_ready(eng_ready), .gnt_valid(gv1), .gnt_id(gid1),
        .pending(pend1), .drop_sts(drop1), .drop_clr(drop_clr)
    );

    dma_start_arbiter_mc #(.ARB_MODE(2), .STARVE_LIMIT(10)) u_tl (
        .clock(clock), .reset(reset), .start_req(start_req), .cancel(cancel),
        .hi_pri(hi_pri), .eng_ready(eng_ready), .gnt_valid(gv2), .gnt_id(gid2),
        .pending(pend2), .drop_sts(drop2), .drop_clr(drop_clr)
    );

    typedef struct {
        logic [7:0] req;
        logic [3:0] cncl;
        logic       rdy;
        logic [3:0] clr;
        logic       ev;
        logic [1:0] eid;
        logic [3:0] ep;
        logic [3:0] ed;
    } vec_t;

    vec_t tbl [16];

    // gnt_id is only compared while an offer is expected
    task automatic chk(input string nm, input int d, input logic ev,
                       input logic [1:0] eid, input logic [3:0] ep,
                       input logic [3:0] ed);
        logic       av;
        logic [1:0] aid;
        logic [3:0] ap, ad;
        case (d)
            0:       begin av = gv0; aid = gid0; ap = pend0; ad = drop0; end
            1:       begin av = gv1; aid = gid1; ap = pend1; ad = drop1; end
            default: begin av = gv2; aid = gid2; ap = pend2; ad = drop2; end
        endcase
        tests++;
        if ((av !== ev) || (ap !== ep) || (ad !== ed) || (ev && (aid !== eid))) begin
            fails++;
            $display("FAIL %s: got valid=%0b id=%0d pending=%b drop=%b, want valid=%0b id=%0d pending=%b drop=%b",
                     nm, av, aid, ap, ad, ev, eid, ep, ed);
        end
    endtask

    // Called at a negedge: drive, pass one posedge, return at the next negedge.
    task automatic step(input logic [7:0] r, input logic [3:0] c,
                        input logic rdy, input logic [3:0] clr);
        start_req = r;
        cancel    = c;
        eng_ready = rdy;
        drop_clr  = clr;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        start_req = '0;
        cancel    = '0;
        eng_ready = 1'b0;
        drop_clr  = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;

        //        req    cncl  rdy   clr   ev    id    pend   drop
        // round-robin: BDs 0,2,3 together, engine always ready
        tbl[0]  = '{8'h0D, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'hD, 4'h0};
        tbl[1]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b1, 2'd0, 4'hD, 4'h0};
        tbl[2]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'hC, 4'h0};
        tbl[3]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b1, 2'd2, 4'hC, 4'h0};
        tbl[4]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h8, 4'h0};
        tbl[5]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b1, 2'd3, 4'h8, 4'h0};
        tbl[6]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0};
        tbl[7]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0};
        // source 1 requests BD 1; re-request during acceptance re-queues it
        tbl[8]  = '{8'h20, 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 4'h2, 4'h0};
        tbl[9]  = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b1, 2'd1, 4'h2, 4'h0};
        tbl[10] = '{8'h20, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h2, 4'h0};
        tbl[11] = '{8'h00, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h0};
        // request while pending and not accepted: drop, set beats clear
        tbl[12] = '{8'h02, 4'h0, 1'b0, 4'h0, 1'b1, 2'd1, 4'h2, 4'h2};
        tbl[13] = '{8'h02, 4'h0, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2, 4'h2};
        tbl[14] = '{8'h00, 4'h0, 1'b0, 4'h2, 1'b1, 2'd1, 4'h2, 4'h0};
        tbl[15] = '{8'h00, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0, 4'h0, 4'h0};

        // ---------------- reset state ----------------
        @(negedge clock);
        @(negedge clock);
        chk("reset_rr", 0, 1'b0, 2'd0, 4'h0, 4'h0);
        chk("reset_fp", 1, 1'b0, 2'd0, 4'h0, 4'h0);
        chk("reset_tl", 2, 1'b0, 2'd0, 4'h0, 4'h0);
        reset = 1'b0;

        // ---------------- table: round-robin + simultaneity ----------------
        for (int k = 0; k < 16; k++) begin
            step(tbl[k].req, tbl[k].cncl, tbl[k].rdy, tbl[k].clr);
            chk($sformatf("vec%0d", k), 0, tbl[k].ev, tbl[k].eid, tbl[k].ep, tbl[k].ed);
        end

        // ---------------- fixed priority: order 1, 0, 3 ----------------
        do_reset();
        step(8'h0A, 4'h0, 1'b0, 4'h0); chk("fp_req31", 1, 1'b0, 2'd0, 4'hA, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("fp_gnt1",  1, 1'b1, 2'd1, 4'hA, 4'h0);
        step(8'h01, 4'h0, 1'b1, 4'h0); chk("fp_acc1",  1, 1'b0, 2'd0, 4'h9, 4'h0);
        step(8'h00, 4'h0, 1'b1, 4'h0); chk("fp_gnt0",  1, 1'b1, 2'd0, 4'h9, 4'h0);
        step(8'h00, 4'h0, 1'b1, 4'h0); chk("fp_acc0",  1, 1'b0, 2'd0, 4'h8, 4'h0);
        step(8'h00, 4'h0, 1'b1, 4'h0); chk("fp_gnt3",  1, 1'b1, 2'd3, 4'h8, 4'h0);
        step(8'h00, 4'h0, 1'b1, 4'h0); chk("fp_acc3",  1, 1'b0, 2'd0, 4'h0, 4'h0);

        // ---------------- handshake hold and withdraw ----------------
        do_reset();
        step(8'h04, 4'h0, 1'b0, 4'h0); chk("hs_req2",   0, 1'b0, 2'd0, 4'h4, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("hs_offer1", 0, 1'b1, 2'd2, 4'h4, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("hs_hold2",  0, 1'b1, 2'd2, 4'h4, 4'h0);
        step(8'h00, 4'h4, 1'b0, 4'h0); chk("hs_cancel", 0, 1'b0, 2'd0, 4'h0, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("hs_idle",   0, 1'b0, 2'd0, 4'h0, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("hs_idle2",  0, 1'b0, 2'd0, 4'h0, 4'h0);
        // pointer still 0 after the withdraw, so BD 1 beats BD 3
        step(8'h0A, 4'h0, 1'b0, 4'h0); chk("hs_req31",  0, 1'b0, 2'd0, 4'hA, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("hs_ptr",    0, 1'b1, 2'd1, 4'hA, 4'h0);

        // ---------------- two-level priority with aging ----------------
        do_reset();
        step(8'h0B, 4'h0, 1'b1, 4'h0);
        found = 0;
        for (int c = 2; c <= 40; c++) begin
            step(8'h03, 4'h0, 1'b1, 4'h0);
            if (gv2 && (gid2 == 2'd3)) begin
                found = c;
                break;
            end
        end
        tests++;
        if ((found < 11) || (found > 18)) begin
            fails++;
            $display("FAIL tl_starve: BD3 first offered at cycle %0d, want 11..18 (0 = never)", found);
        end
        for (int c = 0; c < 8; c++) begin
            step(8'h00, 4'h0, 1'b1, 4'h0);
        end
        chk("tl_drain", 2, 1'b0, 2'd0, 4'h0, 4'h3);

        // ---------------- asynchronous reset during an offer ----------------
        do_reset();
        step(8'h02, 4'h0, 1'b0, 4'h0); chk("ar_req1",  0, 1'b0, 2'd0, 4'h2, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("ar_offer", 0, 1'b1, 2'd1, 4'h2, 4'h0);
        step(8'h02, 4'h0, 1'b0, 4'h0); chk("ar_drop",  0, 1'b1, 2'd1, 4'h2, 4'h2);
        start_req = '0;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_async", 0, 1'b0, 2'd0, 4'h0, 4'h0);
        @(negedge clock);
        reset = 1'b0;
        step(8'h01, 4'h0, 1'b0, 4'h0); chk("ar_req0",  0, 1'b0, 2'd0, 4'h1, 4'h0);
        step(8'h00, 4'h0, 1'b0, 4'h0); chk("ar_gnt0",  0, 1'b1, 2'd0, 4'h1, 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
